// File: rtl/pwm_gen.sv
// Free-running N-bit PWM generator: period of 2^WIDTH clocks, duty sampled at
// count==0 so a width change never glitches the period in progress.
module pwm_gen #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] width,
   output logic             pwm,
   output logic             period_start
);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] duty_q, duty_d;
   logic             pwm_q, pwm_d;
   logic             ps_q, ps_d;

   always_comb begin
      count_d = count_q;
      duty_d  = duty_q;
      pwm_d   = pwm_q;
      ps_d    = 1'b0;
      if (en) begin
         count_d = count_q + 1'b1;
         ps_d    = (count_q == '0);
         if (count_q == '0) begin
            // First slot of the period uses the live width so width=0 never pulses.
            duty_d = width;
            pwm_d  = (width != '0);
         end else begin
            pwm_d  = (count_q < duty_q);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         duty_q  <= '0;
         pwm_q   <= 1'b0;
         ps_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         duty_q  <= duty_d;
         pwm_q   <= pwm_d;
         ps_q    <= ps_d;
      end
   end

   assign pwm          = pwm_q;
   assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_gen.sv
// Randomised bench for pwm_gen: a period-position reference model plus
// per-period high-time and period-length measurements.
module tb_pwm_gen;
   localparam int W = 8;
   localparam int P = 1 << W;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en  = 1'b1;
   logic [W-1:0] width = '0;
   logic         pwm, period_start;

   int n_cmp = 0;
   int n_err = 0;

   // reference: position within the period and the duty latched at its start
   int   m_pos  = 0;
   int   m_duty = 0;
   logic m_pwm  = 1'b0;
   logic m_ps   = 1'b0;

   pwm_gen #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .en(en), .width(width),
      .pwm(pwm), .period_start(period_start)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_pos = 0; m_duty = 0; m_pwm = 1'b0; m_ps = 1'b0;
      end else if (en) begin
         if (m_pos == 0) m_duty = int'(width);
         m_pwm = (m_pos < m_duty);
         m_ps  = (m_pos == 0);
         m_pos = (m_pos + 1) % P;
      end else begin
         m_ps = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; width = 8'h55;
      repeat (5) tick();
      n_cmp++;
      if (pwm !== 1'b0 || period_start !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: pwm=%b ps=%b required 0 0", pwm, period_start);
      end
      rst = 1'b0; width = 8'h0A;
      tick();
      n_cmp++;
      if (pwm !== 1'b1 || period_start !== 1'b1) begin
         n_err++;
         $display("FAIL first_period: pwm=%b ps=%b required 1 1", pwm, period_start);
      end
   endtask

   // Hold width a, switch to b at cycle sw, measure nper periods.
   task automatic test_widths(input logic [W-1:0] a, input logic [W-1:0] b,
                              input int sw, input int nper);
      int hi = 0, gap = 0, duty_cur = 0, nstart = 0;
      bit started = 0;
      width = a;
      for (int c = 0; c < nper * P + P; c++) begin
         if (c == sw) width = b;
         tick();
         gap++;
         n_cmp++;
         if (pwm !== m_pwm || period_start !== m_ps) begin
            n_err++;
            $display("FAIL cycle_w%0d_%0d: c=%0d pwm=%b ps=%b required %b %b",
                     a, b, c, pwm, period_start, m_pwm, m_ps);
         end
         if (period_start) begin
            nstart++;
            if (started) begin
               n_cmp++;
               if (hi != duty_cur || gap != P) begin
                  n_err++;
                  $display("FAIL period_w%0d_%0d: high=%0d len=%0d required %0d %0d",
                           a, b, hi, gap, duty_cur, P);
               end
            end
            started = 1; duty_cur = m_duty; hi = 0; gap = 0;
         end
         if (pwm) hi++;
      end
      n_cmp++;
      if (nstart < nper) begin
         n_err++;
         $display("FAIL strobe_count_w%0d: got %0d required >=%0d", a, nstart, nper);
      end
   endtask

   task automatic test_reset_mid();
      int hi = 0, gap = 0, guard = 0;
      width = 8'd160;
      while (m_pos != 100 && guard < 2 * P) begin tick(); guard++; end
      rst = 1'b1;
      tick();
      n_cmp++;
      if (pwm !== 1'b0 || period_start !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid: pwm=%b ps=%b required 0 0", pwm, period_start);
      end
      rst = 1'b0;
      tick();
      n_cmp++;
      if (pwm !== 1'b1 || period_start !== 1'b1) begin
         n_err++;
         $display("FAIL reset_restart: pwm=%b ps=%b required 1 1", pwm, period_start);
      end
      hi = 1;
      do begin
         tick(); gap++;
         if (pwm && !period_start) hi++;
      end while (!period_start && gap < 2 * P);
      n_cmp++;
      if (hi != 160 || gap != P) begin
         n_err++;
         $display("FAIL reset_pulse: high=%0d len=%0d required 160 %0d", hi, gap, P);
      end
   endtask

   task automatic test_enable();
      int gap = 0, guard = 0;
      logic held;
      width = 8'd40;
      do begin tick(); guard++; end while (!period_start && guard < 2 * P);
      repeat (20) begin tick(); gap++; end
      held = pwm; en = 1'b0;
      repeat (50) begin
         tick(); gap++;
         n_cmp++;
         if (pwm !== held || period_start !== 1'b0) begin
            n_err++;
            $display("FAIL enable_hold: pwm=%b ps=%b required %b 0", pwm, period_start, held);
         end
      end
      en = 1'b1;
      do begin
         tick(); gap++;
         n_cmp++;
         if (pwm !== m_pwm) begin
            n_err++;
            $display("FAIL enable_resume: pwm=%b required %b", pwm, m_pwm);
         end
      end while (!period_start && gap < 3 * P);
      n_cmp++;
      if (gap != P + 50) begin
         n_err++;
         $display("FAIL enable_stretch: len=%0d required %0d", gap, P + 50);
      end
   endtask

   task automatic test_random();
      int hi = 0, duty_cur = 0;
      bit started = 0;
      for (int c = 0; c < 8 * P; c++) begin
         if ($urandom_range(0, 63) == 0) width = W'($urandom);
         tick();
         n_cmp++;
         if (pwm !== m_pwm || period_start !== m_ps) begin
            n_err++;
            $display("FAIL random_cycle: c=%0d pwm=%b ps=%b required %b %b",
                     c, pwm, period_start, m_pwm, m_ps);
         end
         if (period_start) begin
            if (started) begin
               n_cmp++;
               if (hi != duty_cur) begin
                  n_err++;
                  $display("FAIL random_period: high=%0d required %0d", hi, duty_cur);
               end
            end
            started = 1; duty_cur = m_duty; hi = 0;
         end
         if (pwm) hi++;
      end
   endtask

   initial begin
      test_reset();
      test_widths(8'h0A, 8'h0A, -1, 4);
      test_widths(8'hA0, 8'h6D, 2 * P + 100, 4);
      test_widths(8'hFF, 8'h00, 2 * P + 37, 4);
      test_widths(8'h01, 8'h01, -1, 3);
      test_reset_mid();
      test_enable();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
